// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  localparam int DW_DEF = 32;
  localparam int VW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Iteration counter must hold the value DW itself, hence the extra bit.
  function automatic int cnt_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and seq_divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int VW = 16
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  logic [VW:0] t;
  logic [VW:0] dvs_ext;

  // r_i is always below the divisor, so its top bit is zero on entry; the
  // extra bit only matters for the shifted value t.
  logic unused_r_msb;
  assign unused_r_msb = r_i[VW];

  assign t       = {r_i[VW-1:0], bit_i};
  assign dvs_ext = {1'b0, divisor_i};

  // Trial subtraction and quotient bit selection.
  always_comb begin
    r_o     = t;
    q_bit_o = 1'b0;
    if (t >= dvs_ext) begin
      r_o     = t - dvs_ext;
      q_bit_o = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Results and div_by_zero are registered and hold until the next accept.
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(DW);

  div_state_e       state_q, state_d;
  logic [DW-1:0]    q_sh_q, q_sh_d;
  logic [VW:0]      r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VW-1:0]    divisor_q, divisor_d;
  logic [DW-1:0]    quotient_q, quotient_d;
  logic [VW-1:0]    remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [VW:0]      step_r;
  logic             step_q_bit;

  div_step #(.VW(VW)) u_step (
    .r_i       (r_q),
    .bit_i     (q_sh_q[DW-1]),
    .divisor_i (divisor_q),
    .r_o       (step_r),
    .q_bit_o   (step_q_bit)
  );

  // Next-state and datapath update; everything holds unless the state acts.
  always_comb begin
    state_d     = state_q;
    q_sh_d      = q_sh_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d     = FIN;
            quotient_d  = '1;
            remainder_d = bus.dividend[VW-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d   = RUN;
            q_sh_d    = bus.dividend;
            r_d       = '0;
            cnt_d     = CNT_W'(DW);
            divisor_d = bus.divisor;
            dbz_d     = 1'b0;
          end
        end
      end
      RUN: begin
        q_sh_d = {q_sh_q[DW-2:0], step_q_bit};
        r_d    = step_r;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = FIN;
          quotient_d  = {q_sh_q[DW-2:0], step_q_bit};
          remainder_d = step_r[VW-1:0];
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sh_q      <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      q_sh_q      <= q_sh_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FIN);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int DW = 32;
  localparam int VW = 16;

  logic clk = 1'b0;
  logic rst;

  seq_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] dvd, input logic [15:0] dvs,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic z);
    if (dvs == 16'd0) begin
      q = 32'hFFFF_FFFF;
      r = dvd[15:0];
      z = 1'b1;
    end else begin
      q = dvd / {16'd0, dvs};
      r = 16'(dvd % {16'd0, dvs});
      z = 1'b0;
    end
  endfunction

  // Called 1ns after an edge with the divider idle; returns 1ns after accept.
  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
  endtask

  // elapsed = clock edges already seen since the accept edge.
  task automatic wait_done(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                           input int elapsed, input bit poke_fin);
    logic [31:0] eq;
    logic [15:0] er;
    logic        ez;
    int n;
    ref_div(dvd, dvs, eq, er, ez);
    n = elapsed;
    while (!bus.done && n < DW + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, (dvs == 16'd0) ? 0 : DW);
    chk({tag, "_quot"}, bus.quotient, eq);
    chk({tag, "_rem"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, ez);
    chk({tag, "_busy_in_fin"}, bus.busy, 1);
    if (poke_fin) begin
      bus.dividend = 32'd77;
      bus.divisor  = 16'd5;
      bus.start    = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_busy_drop"}, bus.busy, 0);
    if (poke_fin) begin
      @(posedge clk); #1;
      chk({tag, "_fin_ignored"}, bus.busy, 0);
      chk({tag, "_fin_hold_q"}, bus.quotient, eq);
      chk({tag, "_fin_hold_r"}, bus.remainder, er);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] dvd, input logic [15:0] dvs);
    start_op(dvd, dvs);
    wait_done(tag, dvd, dvs, 0, 1'b0);
  endtask

  logic [31:0] ext_dvd [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd5, 32'd0};
  logic [15:0] ext_dvs [4] = '{16'hFFFF, 16'hFFFF, 16'd9, 16'd1};

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quot", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Closed loop with a multiplier product.
    run("loop_11x33", 32'd363, 16'd33);
    for (int a = 0; a < 10; a++) begin
      for (int b = 1; b < 10; b++) begin
        run("sweep", 32'(a * b), 16'(b));
      end
    end

    // Reset in the middle of a run discards it.
    begin
      bit seen;
      start_op(32'd1000, 16'd7);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_quot", bus.quotient, 0);
      chk("midrst_rem", bus.remainder, 0);
      chk("midrst_dbz", bus.div_by_zero, 0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.done) seen = 1'b1;
      end
      chk("midrst_no_done", seen, 0);
      run("after_rst", 32'd1000, 16'd7);
    end

    for (int i = 0; i < 4; i++) run("extreme", ext_dvd[i], ext_dvs[i]);

    // Divide by zero, then a normal division clears the flag.
    run("dbz", 32'd1234, 16'd0);
    run("after_dbz", 32'd20, 16'd4);

    // Start held high: one accept every DW+2 cycles.
    begin
      int cyc, t_prev, acc;
      logic b_prev;
      cyc = 0; t_prev = -1; acc = 0;
      b_prev = bus.busy;
      bus.dividend = 32'd50;
      bus.divisor  = 16'd3;
      bus.start    = 1'b1;
      for (int i = 0; i < 3 * (DW + 2) + 3; i++) begin
        @(posedge clk); #1;
        cyc++;
        if (bus.busy && !b_prev) begin
          if (t_prev >= 0) chk("hold_gap", cyc - t_prev, DW + 2);
          t_prev = cyc;
          acc++;
        end
        if (bus.done) chk("hold_quot", bus.quotient, 16);
        b_prev = bus.busy;
      end
      bus.start = 1'b0;
      chk("hold_accepts", acc, 4);
      repeat (DW + 8) @(posedge clk);
      #1;
      chk("hold_drained", bus.busy, 0);
    end

    // Start pulses during RUN and FIN are ignored.
    start_op(32'd50, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    bus.dividend = 32'd77;
    bus.divisor  = 16'd5;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("pulse", 32'd50, 16'd3, 6, 1'b1);

    // Operand changes mid-run have no effect.
    start_op(32'd1000, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    bus.dividend = 32'd9999;
    bus.divisor  = 16'd3;
    wait_done("midchg", 32'd1000, 16'd7, 5, 1'b0);

    // Randomized operands.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] dvd;
      logic [15:0] dvs;
      dvd = $urandom;
      dvs = 16'($urandom);
      case (i % 5)
        0: dvs = 16'($urandom_range(1, 15));
        1: dvd = 32'($urandom_range(0, 65535)) * {16'd0, dvs};
        2: dvd = 32'($urandom_range(0, 40000));
        default: ;
      endcase
      if (i % 10 == 9) dvs = 16'd0;
      run("random", dvd, dvs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
